// File: rtl/mux_4t1_rr_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 mux channel.
// Each grant forwards up to MAX_BURST words over a valid/ready handshake.
module mux_4t1_rr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    input  logic [W-1:0] D,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   sel,
    output logic [3:0]   grant
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       r_state;
    logic [1:0]   r_sel;
    logic [3:0]   r_grant;
    logic [1:0]   r_last;
    logic [7:0]   r_count;

    logic [1:0]   w_winner;
    logic [W-1:0] w_word;
    logic         w_xfer;
    logic         w_release;

    // Scan offsets from farthest to nearest so the nearest requester after r_last wins.
    always_comb begin
        w_winner = r_last + 2'd1;
        for (int i = 3; i >= 0; i--) begin
            if (req[r_last + 2'(i + 1)])
                w_winner = r_last + 2'(i + 1);
        end
    end

    always_comb begin
        case (r_sel)
            2'd0:    w_word = A;
            2'd1:    w_word = B;
            2'd2:    w_word = C;
            default: w_word = D;
        endcase
    end

    assign out_valid = (r_state == GRANT) && req[r_sel];
    assign out_data  = (r_state == GRANT) ? w_word : '0;
    assign w_xfer    = out_valid && out_ready;
    assign w_release = !req[r_sel] || (w_xfer && (r_count == 8'(MAX_BURST - 1)));

    assign sel   = r_sel;
    assign grant = r_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 2'b00;
            r_grant <= 4'b0000;
            r_last  <= 2'd3;
            r_count <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_grant <= 4'b0000;
                    if (|req) begin
                        r_grant <= 4'b0001 << w_winner;
                        r_sel   <= w_winner;
                        r_count <= 8'd0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_grant <= 4'b0000;
                        r_last  <= r_sel;
                        r_count <= 8'd0;
                    end else if (w_xfer) begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4t1_rr_arbiter.sv
// Scoreboard bench for mux_4t1_rr_arbiter: MAX_BURST=4 and MAX_BURST=1 instances
// share stimulus and are checked against a requester-level reference model.
module tb_mux_4t1_rr_arbiter;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      req = 4'b0000;
    logic [7:0]      A = 8'hA0, B = 8'hB1, C = 8'hC2, D = 8'hD3;
    logic            rdy = 1'b0;
    logic [1:0]      ov;
    logic [1:0][7:0] od;
    logic [1:0][1:0] sl;
    logic [1:0][3:0] gr;

    mux_4t1_rr_arbiter #(.W(8), .MAX_BURST(4)) u4 (
        .clk(clk), .rst(rst), .req(req), .A(A), .B(B), .C(C), .D(D),
        .out_ready(rdy), .out_valid(ov[0]), .out_data(od[0]), .sel(sl[0]), .grant(gr[0]));

    mux_4t1_rr_arbiter #(.W(8), .MAX_BURST(1)) u1 (
        .clk(clk), .rst(rst), .req(req), .A(A), .B(B), .C(C), .D(D),
        .out_ready(rdy), .out_valid(ov[1]), .out_data(od[1]), .sel(sl[1]), .grant(gr[1]));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
        logic [7:0] d;
    } st_t;

    st_t        sq0[$], sq1[$];
    logic [9:0] xq0[$], xq1[$];
    int         n_cmp = 0, n_bad = 0;
    bit         run = 0;
    int         owner[2], last[2], cnt[2], esel[2];
    int         mb[2] = '{4, 1};

    function automatic logic [7:0] word(int i);
        case (i)
            0:       return A;
            1:       return B;
            2:       return C;
            default: return D;
        endcase
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; last[k] = 3; cnt[k] = 0; esel[k] = 0;
        end
    endtask

    // Requester-level view: who owns the channel, how many words it has sent.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (owner[k] < 0) begin
                for (int i = 1; i <= 4; i++) begin
                    if (req[(last[k] + i) % 4]) begin
                        owner[k] = (last[k] + i) % 4;
                        break;
                    end
                end
                if (owner[k] >= 0) begin
                    esel[k] = owner[k];
                    cnt[k]  = 0;
                end
            end else if (!req[owner[k]] || (rdy && cnt[k] + 1 == mb[k])) begin
                last[k]  = owner[k];
                owner[k] = -1;
            end else if (rdy) begin
                cnt[k]++;
            end
        end
    endtask

    task automatic model_push();
        st_t st;
        for (int k = 0; k < 2; k++) begin
            st.g = (owner[k] < 0) ? 4'b0000 : 4'(1 << owner[k]);
            st.s = 2'(esel[k]);
            st.v = (owner[k] >= 0) && req[owner[k]];
            st.d = (owner[k] >= 0) ? word(owner[k]) : 8'h00;
            if (k == 0) sq0.push_back(st); else sq1.push_back(st);
            if (st.v && rdy) begin
                if (k == 0) xq0.push_back({st.s, st.d}); else xq1.push_back({st.s, st.d});
            end
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic rd, input bit rnd);
        @(posedge clk);
        model_edge();
        #1;
        req = r;
        rdy = rd;
        if (rnd) begin
            A = 8'($urandom); B = 8'($urandom); C = 8'($urandom); D = 8'($urandom);
        end
        model_push();
    endtask

    // Async reset inside a cycle; outputs must clear before any clock edge.
    task automatic do_reset(input logic [3:0] r_after);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_grant%0d", k), 32'(gr[k]), 32'h0);
            check($sformatf("rst_sel%0d", k), 32'(sl[k]), 32'h0);
            check($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'h0);
            check($sformatf("rst_data%0d", k), 32'(od[k]), 32'h0);
        end
        sq0.delete(); sq1.delete(); xq0.delete(); xq1.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = r_after;
        model_push();
    endtask

    always @(negedge clk) begin
        if (run && !rst) begin
            for (int k = 0; k < 2; k++) begin
                st_t st;
                logic [9:0] x;
                if ((k == 0 ? sq0.size() : sq1.size()) == 0) begin
                    check($sformatf("status_q_empty%0d", k), 32'd0, 32'd1);
                end else begin
                    st = (k == 0) ? sq0.pop_front() : sq1.pop_front();
                    check($sformatf("grant%0d", k), 32'(gr[k]), 32'(st.g));
                    check($sformatf("sel%0d", k), 32'(sl[k]), 32'(st.s));
                    check($sformatf("valid%0d", k), 32'(ov[k]), 32'(st.v));
                    check($sformatf("data%0d", k), 32'(od[k]), 32'(st.d));
                end
                if (ov[k] && rdy) begin
                    if ((k == 0 ? xq0.size() : xq1.size()) == 0) begin
                        check($sformatf("unexpected_xfer%0d", k), 32'(od[k]), 32'h100);
                    end else begin
                        x = (k == 0) ? xq0.pop_front() : xq1.pop_front();
                        check($sformatf("xfer%0d", k), 32'({sl[k], od[k]}), 32'(x));
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("init_grant%0d", k), 32'(gr[k]), 32'h0);
            check($sformatf("init_sel%0d", k), 32'(sl[k]), 32'h0);
            check($sformatf("init_valid%0d", k), 32'(ov[k]), 32'h0);
            check($sformatf("init_data%0d", k), 32'(od[k]), 32'h0);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        run = 1;
        model_push();

        // Reset in the middle of a C burst, then C wins over D from a fresh pointer.
        cycle(4'b0100, 1'b1, 0);
        repeat (3) cycle(4'b0100, 1'b1, 0);
        do_reset(4'b1100);
        cycle(4'b1100, 1'b1, 0);
        check("c_after_reset", 32'(gr[0]), 32'h4);
        repeat (10) cycle(4'b1100, 1'b1, 0);

        // All requesting, fresh pointer: A,B,C,D,A rotation.
        do_reset(4'b1111);
        cycle(4'b1111, 1'b1, 0);
        check("a_first", 32'(gr[0]), 32'h1);
        repeat (26) cycle(4'b1111, 1'b1, 0);

        repeat (20) cycle(4'b0100, 1'b1, 0);
        repeat (30) cycle(4'b0010, 1'($urandom), 0);
        repeat (3) cycle(4'b0011, 1'b1, 0);
        repeat (6) cycle(4'b0010, 1'b1, 0);
        repeat (20) cycle(4'b1010, 1'b1, 0);

        r = 4'b0000;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            cycle(r, 1'($urandom_range(0, 3) != 0), 1);
        end
        repeat (4) cycle(4'b0000, 1'b1, 0);
        @(negedge clk);
        #1;
        check("xq0_drained", 32'(xq0.size()), 32'd0);
        check("xq1_drained", 32'(xq1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
